// File: rtl/embedding_pkg.sv
// embedding_pkg: shared types and helpers for the embedding stream unit.
//   state_e   - controller states
//   TOK_SEL_C - weight-store tensor select for the token table
//   POS_SEL_C - weight-store tensor select for the position table
//   sat_add8  - signed int8 add, saturating or wrapping
package embedding_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOK = 3'd1,
        RD_POS = 3'd2,
        ADD    = 3'd3,
        EMIT   = 3'd4,
        FIN    = 3'd5
    } state_e;

    localparam logic [5:0] TOK_SEL_C = 6'd0;
    localparam logic [5:0] POS_SEL_C = 6'd1;

    // A 9-bit signed sum overflows int8 exactly when bits 8 and 7 differ;
    // bit 8 is then the true sign and selects the clamp direction.
    function automatic logic [7:0] sat_add8(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       saturate);
        logic [8:0] s;
        logic [7:0] r;
        s = {a[7], a} + {b[7], b};
        r = s[7:0];
        if (saturate && (s[8] != s[7])) begin
            r = s[8] ? 8'h80 : 8'h7F;
        end
        return r;
    endfunction

endpackage

// File: rtl/embed_lane_add.sv
// embed_lane_add: one signed int8 lane adder.
//   a_i   - token byte (int8)
//   b_i   - position byte (int8)
//   sum_o - a_i + b_i, clamped to [-128,127] when SATURATE, else low 8 bits
module embed_lane_add
    import embedding_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] sum_o
);

    assign sum_o = sat_add8(a_i, b_i, SATURATE);

endmodule

// File: rtl/embedding_stream.sv
// embedding_stream: per request, reads a token row and a position row from the
// weight store LANES bytes at a time, adds them lane-wise as int8 and streams
// the DIM-element result in LANES-wide beats.
//
// Ports:
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   req_valid_i/ready_o    - request handshake; ready only in IDLE
//   token_id_i, position_i - sampled on the request handshake
//   w_sel_o, w_addr_o      - weight-store tensor select and word address
//   w_data_i               - read data, one cycle after the address
//   out_valid_o/ready_i    - output beat handshake
//   out_data_o             - lane j = element k*LANES+j of chunk k
//   out_idx_o, out_last_o  - chunk index k, high on the final chunk
//   done_o, err_o          - one-cycle completion pulse and error flag
//   busy_o                 - high from the cycle after handshake to done_o
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While out_valid_o is high and out_ready_i low, data, index and
// last are held unchanged; valid never drops without a transfer.
module embedding_stream
    import embedding_pkg::*;
#(
    parameter int         DIM      = 128,
    parameter int         LANES    = 4,
    parameter int         VOCAB    = 256,
    parameter int         MAX_POS  = 256,
    parameter int         ID_W     = 8,
    parameter int         POS_W    = 8,
    parameter int         ADDR_W   = 16,
    parameter logic [5:0] TOK_SEL  = TOK_SEL_C,
    parameter logic [5:0] POS_SEL  = POS_SEL_C,
    parameter int         SATURATE = 1,
    localparam int        CHUNKS   = DIM / LANES,
    localparam int        K_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ID_W-1:0]       token_id_i,
    input  logic [POS_W-1:0]      position_i,
    output logic [5:0]            w_sel_o,
    output logic [ADDR_W-1:0]     w_addr_o,
    input  logic [LANES*8-1:0]    w_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*8-1:0]    out_data_o,
    output logic [K_W-1:0]        out_idx_o,
    output logic                  out_last_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam logic [K_W-1:0] K_LAST = K_W'(CHUNKS - 1);

    state_e                 state_q;
    logic [ID_W-1:0]        tok_q;
    logic [POS_W-1:0]       pos_q;
    logic [K_W-1:0]         k_q;
    logic [LANES*8-1:0]     tok_r_q;
    logic [LANES*8-1:0]     out_data_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic                   done_q;
    logic                   err_q;
    logic                   busy_q;
    logic [5:0]             w_sel_q;
    logic [ADDR_W-1:0]      w_addr_q;

    logic [LANES*8-1:0]     sum_w;
    logic [31:0]            tok_ext;
    logic [31:0]            pos_ext;
    logic                   req_bad;

    // Row base times CHUNKS plus chunk offset, all at ADDR_W width.
    function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] row,
                                                   input logic [K_W-1:0]    k);
        return row * ADDR_W'(CHUNKS) + ADDR_W'(k);
    endfunction

    // Range check at 32 bits so tables smaller than the id space are caught.
    assign tok_ext = 32'(token_id_i);
    assign pos_ext = 32'(position_i);
    assign req_bad = (tok_ext >= 32'(VOCAB)) || (pos_ext >= 32'(MAX_POS));

    // The token word captured in RD_POS meets the position word arriving in ADD.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        embed_lane_add #(
            .SATURATE(SATURATE != 0)
        ) u_lane (
            .a_i  (tok_r_q[j*8 +: 8]),
            .b_i  (w_data_i[j*8 +: 8]),
            .sum_o(sum_w[j*8 +: 8])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            tok_q       <= '0;
            pos_q       <= '0;
            k_q         <= '0;
            tok_r_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            w_sel_q     <= TOK_SEL;
            w_addr_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        tok_q  <= token_id_i;
                        pos_q  <= position_i;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                        if (req_bad) begin
                            // No reads: straight to completion with error.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            // Address is registered here so it is on the bus in RD_TOK.
                            w_sel_q  <= TOK_SEL;
                            w_addr_q <= row_addr(ADDR_W'(token_id_i), '0);
                            state_q  <= RD_TOK;
                        end
                    end
                end
                RD_TOK: begin
                    w_sel_q  <= POS_SEL;
                    w_addr_q <= row_addr(ADDR_W'(pos_q), k_q);
                    state_q  <= RD_POS;
                end
                RD_POS: begin
                    tok_r_q <= w_data_i;
                    state_q <= ADD;
                end
                ADD: begin
                    out_data_q  <= sum_w;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (k_q == K_LAST);
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (k_q == K_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            k_q      <= k_q + 1'b1;
                            w_sel_q  <= TOK_SEL;
                            w_addr_q <= row_addr(ADDR_W'(tok_q), k_q + 1'b1);
                            state_q  <= RD_TOK;
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign w_sel_o     = w_sel_q;
    assign w_addr_o    = w_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = k_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule
